// File: rtl/sr_latch_driver_if.sv
// Command and latch-side signal bundle for sr_latch_driver.
// The slave modport is the driver itself; master is whoever issues commands and models the latch.
interface sr_latch_driver_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_val;
  logic       en;
  logic       s;
  logic       r;
  logic       q_in;
  logic       q_bar_in;
  logic       busy;
  logic       done;
  logic       err;
  logic [3:0] retry_cnt;

  modport slave (
    input  cmd_valid, cmd_val, q_in, q_bar_in,
    output cmd_ready, en, s, r, busy, done, err, retry_cnt
  );

  modport master (
    output cmd_valid, cmd_val, q_in, q_bar_in,
    input  cmd_ready, en, s, r, busy, done, err, retry_cnt
  );
endinterface

// File: rtl/sr_latch_driver.sv
// Drives an enable-gated SR latch with an en/s/r pulse, settles, reads back q/q_bar
// and retries on mismatch; all outputs are registered from the next-state decode.
module sr_latch_driver #(
  parameter int unsigned PULSE_CYC  = 2,
  parameter int unsigned SETTLE_CYC = 2,
  parameter int unsigned MAX_RETRY  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  sr_latch_driver_if.slave   bus
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRIVE  = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_CHECK  = 2'd3;

  localparam logic [7:0] PULSE_LAST  = 8'(PULSE_CYC - 1);
  localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYC - 1);
  localparam logic [3:0] RETRY_MAX   = 4'(MAX_RETRY);
  localparam bit PARAMS_OK = (PULSE_CYC >= 1) && (PULSE_CYC <= 255) &&
                             (SETTLE_CYC >= 1) && (SETTLE_CYC <= 255) &&
                             (MAX_RETRY <= 15);

  logic [1:0] state_reg, state_next;
  logic [7:0] phase_reg, phase_next;
  logic [3:0] retry_reg, retry_next;
  logic       val_reg, val_next;
  logic       done_next, err_next;
  logic       en_reg, s_reg, r_reg, busy_reg, ready_reg, done_reg, err_reg;
  logic       readback_ok;

  // 00 and 11 on q/q_bar are both illegal latch states, so only the exact pair passes.
  assign readback_ok = (bus.q_in == val_reg) && (bus.q_bar_in == ~val_reg);

  always_comb begin
    state_next = state_reg;
    phase_next = phase_reg;
    retry_next = retry_reg;
    val_next   = val_reg;
    done_next  = 1'b0;
    err_next   = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (bus.cmd_valid) begin
          val_next   = bus.cmd_val;
          retry_next = 4'd0;
          phase_next = 8'd0;
          state_next = ST_DRIVE;
        end
      end
      ST_DRIVE: begin
        if (phase_reg == PULSE_LAST) begin
          phase_next = 8'd0;
          state_next = ST_SETTLE;
        end else begin
          phase_next = phase_reg + 8'd1;
        end
      end
      ST_SETTLE: begin
        if (phase_reg == SETTLE_LAST) begin
          phase_next = 8'd0;
          state_next = ST_CHECK;
        end else begin
          phase_next = phase_reg + 8'd1;
        end
      end
      ST_CHECK: begin
        phase_next = 8'd0;
        if (readback_ok) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
        end else if (retry_reg == RETRY_MAX) begin
          state_next = ST_IDLE;
          done_next  = 1'b1;
          err_next   = 1'b1;
        end else begin
          retry_next = retry_reg + 4'd1;
          state_next = ST_DRIVE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Outputs are decoded from the next state so s and r can never overlap, even on transitions.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      phase_reg <= 8'd0;
      retry_reg <= 4'd0;
      val_reg   <= 1'b0;
      en_reg    <= 1'b0;
      s_reg     <= 1'b0;
      r_reg     <= 1'b0;
      busy_reg  <= 1'b0;
      ready_reg <= 1'b1;
      done_reg  <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      phase_reg <= phase_next;
      retry_reg <= retry_next;
      val_reg   <= val_next;
      en_reg    <= (state_next != ST_IDLE);
      s_reg     <= (state_next == ST_DRIVE) &&  val_next;
      r_reg     <= (state_next == ST_DRIVE) && !val_next;
      busy_reg  <= (state_next != ST_IDLE);
      ready_reg <= (state_next == ST_IDLE);
      done_reg  <= done_next;
      err_reg   <= err_next;
    end
  end

  always_ff @(posedge clk) begin
    assert (PARAMS_OK) else $error("sr_latch_driver: parameter out of legal range");
  end

  assign bus.cmd_ready = ready_reg;
  assign bus.en        = en_reg;
  assign bus.s         = s_reg;
  assign bus.r         = r_reg;
  assign bus.busy      = busy_reg;
  assign bus.done      = done_reg;
  assign bus.err       = err_reg;
  assign bus.retry_cnt = retry_reg;

endmodule

// File: tb/tb_sr_latch_driver.sv
// Directed bench for sr_latch_driver with a behavioural SR latch that can be
// made stuck, forced to 11, or made to ignore its first pulse.
module tb_sr_latch_driver;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  sr_latch_driver_if bus ();

  sr_latch_driver #(.PULSE_CYC(2), .SETTLE_CYC(2), .MAX_RETRY(3)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Latch model: mode 0 = tracks pulses, 1 = stuck q=1/q_bar=0, 2 = reads back 11.
  int   mode = 0;
  int   pulse_total = 0;
  int   ignore_until = 0;
  logic lq = 1'b0;

  always @(posedge clk) begin
    if (bus.en && (bus.s || bus.r)) begin
      if (pulse_total >= ignore_until) lq <= bus.s;
      pulse_total <= pulse_total + 1;
    end
  end

  always_comb begin
    bus.q_in     = lq;
    bus.q_bar_in = ~lq;
    if (mode == 1) begin
      bus.q_in     = 1'b1;
      bus.q_bar_in = 1'b0;
    end else if (mode == 2) begin
      bus.q_in     = 1'b1;
      bus.q_bar_in = 1'b1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Called at a sample point with the DUT idle; returns one cycle after done.
  task automatic run_cmd(input string name, input logic v, input int exp_cyc,
                         input logic exp_err, input int exp_retry, input bit detail);
    int cyc;
    int pulses;
    bus.cmd_valid = 1'b1;
    bus.cmd_val   = v;
    check({name, "_ready"}, 32'(bus.cmd_ready), 1);
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    cyc    = 1;
    pulses = 0;
    while (!bus.done && cyc < 100) begin
      check("s_and_r", 32'(bus.s & bus.r), 0);
      check("sr_implies_en", 32'((bus.s | bus.r) & ~bus.en), 0);
      if (detail) begin
        check("en_pattern", 32'(bus.en), 32'(cyc <= 5));
        check("s_pattern", 32'(bus.s), 32'(v && cyc <= 2));
        check("r_pattern", 32'(bus.r), 32'(!v && cyc <= 2));
      end
      if (bus.s || bus.r) pulses++;
      @(negedge clk);
      cyc++;
    end
    check({name, "_done_seen"}, 32'(bus.done), 1);
    check({name, "_done_cycle"}, 32'(cyc), 32'(exp_cyc));
    check({name, "_err"}, 32'(bus.err), 32'(exp_err));
    check({name, "_retry_cnt"}, 32'(bus.retry_cnt), 32'(exp_retry));
    check({name, "_en_at_done"}, 32'(bus.en), 0);
    check({name, "_pulse_cycles"}, 32'(pulses), 32'(2 * (exp_retry + 1)));
    $display("cmd %s val=%0d done_cycle=%0d err=%0d retry_cnt=%0d pulse_cycles=%0d",
             name, v, cyc, bus.err, bus.retry_cnt, pulses);
    @(negedge clk);
  endtask

  initial begin
    int acc_k[$];
    int done_n;
    bit flip;

    rst_n         = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_val   = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(bus.cmd_ready), 1);
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_en_s_r", 32'({bus.en, bus.s, bus.r}), 0);
    check("rst_done_err", 32'({bus.done, bus.err}), 0);
    check("rst_retry", 32'(bus.retry_cnt), 0);
    $display("reset released");
    rst_n = 1'b1;
    @(negedge clk);

    mode = 0;
    run_cmd("set_ok", 1'b1, 6, 1'b0, 0, 1'b1);

    mode = 1;
    run_cmd("reset_stuck", 1'b0, 21, 1'b1, 3, 1'b0);

    mode = 0;
    ignore_until = pulse_total + 2;
    run_cmd("set_late", 1'b1, 11, 1'b0, 1, 1'b0);

    mode = 2;
    run_cmd("readback_11", 1'b1, 21, 1'b1, 3, 1'b0);

    // cmd_valid held high with alternating values: accepts only in IDLE cycles.
    mode   = 0;
    done_n = 0;
    flip   = 1'b0;
    bus.cmd_valid = 1'b1;
    bus.cmd_val   = 1'b1;
    for (int k = 0; k <= 18; k++) begin
      if (flip) begin
        bus.cmd_val = ~bus.cmd_val;
        flip = 1'b0;
      end
      check("stream_s_and_r", 32'(bus.s & bus.r), 0);
      if (k == 1 || k == 13) check("stream_s_pulse", 32'(bus.s), 1);
      if (k == 7) check("stream_r_pulse", 32'(bus.r), 1);
      if (bus.done) begin
        done_n++;
        check("stream_err", 32'(bus.err), 0);
      end
      if (k == 18) bus.cmd_valid = 1'b0;
      else if (bus.cmd_ready) begin
        acc_k.push_back(k);
        flip = 1'b1;
      end
      @(posedge clk);
      @(negedge clk);
    end
    check("stream_accepts", 32'(acc_k.size()), 3);
    if (acc_k.size() == 3) begin
      check("stream_acc0", 32'(acc_k[0]), 0);
      check("stream_acc1", 32'(acc_k[1]), 6);
      check("stream_acc2", 32'(acc_k[2]), 12);
    end
    check("stream_dones", 32'(done_n), 3);
    $display("stream accepts=%0d dones=%0d", acc_k.size(), done_n);

    // Reset during SETTLE aborts the command without a done pulse.
    bus.cmd_valid = 1'b1;
    bus.cmd_val   = 1'b0;
    @(posedge clk);
    @(negedge clk);
    bus.cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort_in_settle_en", 32'(bus.en), 1);
    check("abort_in_settle_s_r", 32'({bus.s, bus.r}), 0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_en_s_r", 32'({bus.en, bus.s, bus.r}), 0);
    check("abort_busy", 32'(bus.busy), 0);
    check("abort_ready", 32'(bus.cmd_ready), 1);
    check("abort_retry", 32'(bus.retry_cnt), 0);
    rst_n  = 1'b1;
    done_n = 0;
    for (int k = 0; k < 8; k++) begin
      if (bus.done) done_n++;
      @(negedge clk);
    end
    check("abort_no_done", 32'(done_n), 0);
    $display("abort during settle done_pulses=%0d", done_n);
    run_cmd("after_reset", 1'b1, 6, 1'b0, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sr_latch_driver.md
Name: sr_latch_driver

Overview:
- Command-driven controller for an external enable-gated SR storage latch: converts a single-bit write request (set or reset) into an en/s/r pulse sequence, then reads back q/q_bar to confirm the latch took the value.
- Retries on readback mismatch up to a limit, then reports completion with a pass/fail flag.
- Sits between control logic and any SR latch cell; guarantees s and r are never asserted together.

Parameters:
- PULSE_CYC, 2, cycles s or r is held asserted with en=1 (legal range 1..255).
- SETTLE_CYC, 2, hold cycles (en=1, s=r=0) before readback (legal range 1..255).
- MAX_RETRY, 3, extra attempts after the first failed check (legal range 0..15).

Ports:
- clk  input  1  clock; all logic on the rising edge.
- rst_n  input  1  synchronous reset, active-low.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high in IDLE only; accept = cmd_valid & cmd_ready at a rising edge.
- cmd_val  input  1  1 = set latch, 0 = reset latch; sampled on accept.
- en  output  1  latch enable.
- s  output  1  latch set.
- r  output  1  latch reset.
- q_in  input  1  latch q readback; must be synchronous to clk.
- q_bar_in  input  1  latch q_bar readback; must be synchronous to clk.
- busy  output  1  high in any non-IDLE state.
- done  output  1  one-cycle completion pulse.
- err  output  1  valid only with done; 1 = readback failed after all retries.
- retry_cnt  output  4  retries used by the last command; held until the next accept.

Behaviour:
- All outputs are registered.
- Reset (rst_n=0 at an edge):
  - state=IDLE; en=s=r=0; done=err=0; busy=0; retry_cnt=0; captured value=0; cmd_ready=1 after reset.
  - Mid-operation reset aborts the command; no done is produced.
- IDLE:
  - en=s=r=0, cmd_ready=1.
  - On accept: capture cmd_val, clear retry_cnt and the phase counter, go to DRIVE.
- DRIVE:
  - en=1, s=val, r=~val for exactly PULSE_CYC cycles, then go to SETTLE.
- SETTLE:
  - en=1, s=r=0 (latch hold code) for exactly SETTLE_CYC cycles, then go to CHECK.
- CHECK (1 cycle, en=1, s=r=0):
  - Pass when q_in==val and q_bar_in==~val. Both equal (00/11) counts as fail.
  - Pass: go to IDLE with done=1, err=0.
  - Fail with retry_cnt<MAX_RETRY: retry_cnt+1, go to DRIVE (new full pulse).
  - Fail with retry_cnt==MAX_RETRY: go to IDLE with done=1, err=1.
- Latency: accept edge to done-high cycle = PULSE_CYC+SETTLE_CYC+2 cycles for a first-try pass (6 at defaults). Each retry adds PULSE_CYC+SETTLE_CYC+1 cycles.
- done and err are high for exactly one cycle, the first IDLE cycle. cmd_ready is also 1 in that cycle, so a back-to-back command may be accepted there; done still pulses for the old command.
- cmd_valid while busy is ignored; cmd_val changes while busy have no effect.
- Invariant: s&r==0 every cycle, including reset and transitions. s|r implies en.
- retry_cnt saturates by construction at MAX_RETRY; no wrap.
- Counters are sized for 255. Out-of-range parameter values are illegal; a simulation-only check flags them.

Test Plan:
- Set, latch model correct: accept cmd_val=1 at edge 0 -> en=1 cycles 1-5; s=1 cycles 1-2; s=r=0 cycles 3-5; done=1, err=0, retry_cnt=0 in cycle 6; en=0 in cycle 6.
- Reset command with model stuck q=1, q_bar=0, MAX_RETRY=3 -> 4 r pulses of 2 cycles each; done=1, err=1, retry_cnt=3 exactly 6+3*5=21 cycles after accept.
- Model fails first check then responds -> second pass succeeds; done cycle 11, err=0, retry_cnt=1.
- cmd_valid held high continuously, alternating cmd_val -> accepts only in IDLE/done cycles (edges 0, 6, 12...); s&r never 1; one done per command.
- Readback q_in=q_bar_in=1 at CHECK -> treated as fail, retry issued.
- rst_n=0 during SETTLE -> next cycle en=s=r=0, busy=0, no done; new command after reset completes normally with latency 6.
